// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage ahead of the 32-bit ALU: turns MIPS opcode/funct into an ALU opselect
// and operands, and queues up to two issued operations in a skid buffer toward EX/MEM.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  opselect,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] store_data,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal
);

  typedef struct packed {
    logic [3:0]  opselect;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } entry_t;

  entry_t      dec;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      out_e;
  logic [1:0]  count_q, count_d;
  logic        legal;
  logic        wb;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        push;
  logic        pop;

  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'h0000, imm};

  always_comb begin
    dec            = '0;
    dec.opselect   = 4'b1111;
    dec.x          = rs_data;
    dec.y          = rt_data;
    dec.store_data = rt_data;
    legal          = 1'b1;
    wb             = 1'b0;
    case (opcode)
      6'h00: begin
        dec.dest = rd_addr;
        wb       = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.opselect = 4'b0000;
          6'h22, 6'h23: dec.opselect = 4'b0001;
          6'h24:        dec.opselect = 4'b1001;
          6'h25:        dec.opselect = 4'b1010;
          6'h26:        dec.opselect = 4'b1101;
          6'h27:        dec.opselect = 4'b1100;
          6'h2A:        dec.opselect = 4'b0111;
          default:      legal        = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.opselect = 4'b0000; dec.y = sext; dec.dest = rt_addr; wb = 1'b1; end
      6'h0A:        begin dec.opselect = 4'b0111; dec.y = sext; dec.dest = rt_addr; wb = 1'b1; end
      6'h0C:        begin dec.opselect = 4'b1001; dec.y = zext; dec.dest = rt_addr; wb = 1'b1; end
      6'h0D:        begin dec.opselect = 4'b1010; dec.y = zext; dec.dest = rt_addr; wb = 1'b1; end
      6'h0E:        begin dec.opselect = 4'b1101; dec.y = zext; dec.dest = rt_addr; wb = 1'b1; end
      6'h23: begin
        dec.opselect = 4'b0000;
        dec.y        = sext;
        dec.dest     = rt_addr;
        dec.mem_read = 1'b1;
        wb           = 1'b1;
      end
      6'h2B: begin dec.opselect = 4'b0000; dec.y = sext; dec.mem_write = 1'b1; end
      6'h04: begin dec.opselect = 4'b1000; dec.branch = 1'b1; end
      default: legal = 1'b0;
    endcase
    // Unsupported encodings still occupy a slot but carry no side effects.
    if (!legal) begin
      dec.opselect  = 4'b1111;
      dec.illegal   = 1'b1;
      dec.dest      = '0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      wb            = 1'b0;
    end
    dec.reg_write = wb & (dec.dest != 5'd0);
  end

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Push+pop only coexist at count 1 (empty blocks pop, full blocks push), so the new entry becomes head.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = dec;
          else                 tail_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11:   head_d = dec;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    out_e = head_q;
    if (!out_valid) begin
      out_e          = '0;
      out_e.opselect = 4'b1111;
    end
  end

  assign opselect   = out_e.opselect;
  assign x          = out_e.x;
  assign y          = out_e.y;
  assign store_data = out_e.store_data;
  assign dest       = out_e.dest;
  assign reg_write  = out_e.reg_write;
  assign mem_read   = out_e.mem_read;
  assign mem_write  = out_e.mem_write;
  assign branch     = out_e.branch;
  assign illegal    = out_e.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected entries are queued on acceptance and
// compared when the head is consumed.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [4:0]  rt_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  opselect;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] store_data;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;

  int checks = 0;
  int failures = 0;
  int next_id = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, il;
    bit          xy_care, dest_care;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t m;

  alu_issue_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .imm(imm), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid), .out_ready(out_ready),
    .opselect(opselect), .x(x), .y(y), .store_data(store_data), .dest(dest),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    logic [31:0] se, ze;
    se = {{16{im[15]}}, im};
    ze = {16'h0000, im};
    e.op = 4'hF; e.x = rsd; e.y = rtd; e.sd = rtd; e.dest = 5'd0;
    e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.il = 0;
    e.xy_care = 1; e.dest_care = 0; e.id = 0;
    if (op == 6'h00) begin
      e.dest = rd; e.dest_care = 1; e.rw = (rd != 5'd0);
      if (fn == 6'h20 || fn == 6'h21) e.op = 4'b0000;
      else if (fn == 6'h22 || fn == 6'h23) e.op = 4'b0001;
      else if (fn == 6'h24) e.op = 4'b1001;
      else if (fn == 6'h25) e.op = 4'b1010;
      else if (fn == 6'h26) e.op = 4'b1101;
      else if (fn == 6'h27) e.op = 4'b1100;
      else if (fn == 6'h2A) e.op = 4'b0111;
      else e.il = 1;
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h0A) begin
      e.op = (op == 6'h0A) ? 4'b0111 : 4'b0000; e.y = se;
      e.dest = rt; e.dest_care = 1; e.rw = (rt != 5'd0);
    end else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
      e.op = (op == 6'h0C) ? 4'b1001 : (op == 6'h0D) ? 4'b1010 : 4'b1101; e.y = ze;
      e.dest = rt; e.dest_care = 1; e.rw = (rt != 5'd0);
    end else if (op == 6'h23) begin
      e.op = 4'b0000; e.y = se; e.mr = 1;
      e.dest = rt; e.dest_care = 1; e.rw = (rt != 5'd0);
    end else if (op == 6'h2B) begin
      e.op = 4'b0000; e.y = se; e.mw = 1;
    end else if (op == 6'h04) begin
      e.op = 4'b1000; e.br = 1;
    end else begin
      e.il = 1;
    end
    if (e.il) begin
      e.op = 4'hF; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0;
      e.xy_care = 0; e.dest_care = 0;
    end
    return e;
  endfunction

  // Scoreboard consumer: the head is compared on the cycle EX/MEM takes it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output got opselect=%h x=%h with no entry expected", opselect, x);
      end else begin
        m = q.pop_front();
        checks++; if (opselect !== m.op) begin failures++; $display("FAIL opselect id=%0d got=%b exp=%b", m.id, opselect, m.op); end
        checks++; if (illegal !== m.il) begin failures++; $display("FAIL illegal id=%0d got=%b exp=%b", m.id, illegal, m.il); end
        checks++; if (reg_write !== m.rw) begin failures++; $display("FAIL reg_write id=%0d got=%b exp=%b", m.id, reg_write, m.rw); end
        checks++; if (mem_read !== m.mr) begin failures++; $display("FAIL mem_read id=%0d got=%b exp=%b", m.id, mem_read, m.mr); end
        checks++; if (mem_write !== m.mw) begin failures++; $display("FAIL mem_write id=%0d got=%b exp=%b", m.id, mem_write, m.mw); end
        checks++; if (branch !== m.br) begin failures++; $display("FAIL branch id=%0d got=%b exp=%b", m.id, branch, m.br); end
        checks++; if (store_data !== m.sd) begin failures++; $display("FAIL store_data id=%0d got=%h exp=%h", m.id, store_data, m.sd); end
        if (m.xy_care) begin
          checks++; if (x !== m.x) begin failures++; $display("FAIL x id=%0d got=%h exp=%h", m.id, x, m.x); end
          checks++; if (y !== m.y) begin failures++; $display("FAIL y id=%0d got=%h exp=%h", m.id, y, m.y); end
        end
        if (m.dest_care) begin
          checks++; if (dest !== m.dest) begin failures++; $display("FAIL dest id=%0d got=%0d exp=%0d", m.id, dest, m.dest); end
        end
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd);
    opcode = op; funct = fn; imm = im; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; in_valid = 1'b1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    bit acc;
    acc = 0;
    drive(op, fn, im, rt, rd, rsd, rtd);
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1;
    end
    checks++;
    if (acc) begin
      e = model(op, fn, im, rt, rd, rsd, rtd);
      e.id = next_id++;
      q.push_back(e);
      @(posedge clk); #1;
    end else begin
      failures++;
      $display("FAIL accept_timeout opcode=%h in_ready=%b required 1 within 40 cycles", op, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #2;
      if (q.size() == 0 && out_valid === 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain pending=%0d out_valid=%b required 0/0", name, q.size(), out_valid);
    end
  endtask

  task automatic check_idle(input string name);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_out_valid got=%b exp=0", name, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready); end
    checks++; if (opselect !== 4'hF) begin failures++; $display("FAIL %s_opselect got=%b exp=1111", name, opselect); end
    checks++;
    if ({x, y, store_data, dest, reg_write, mem_read, mem_write, branch, illegal} !== '0) begin
      failures++;
      $display("FAIL %s_zero_outputs x=%h y=%h sd=%h dest=%0d ctl=%b%b%b%b%b required all 0", name,
               x, y, store_data, dest, reg_write, mem_read, mem_write, branch, illegal);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_idle("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");
  endtask

  task automatic test_alu_ops();
    out_ready = 1'b1;
    offer(6'h00, 6'h20, 16'h0000, 5'd7, 5'd3, 32'd5, 32'd7);
    // Latency: the first entry must already be at the head one edge after acceptance.
    #2;
    checks++; if (out_valid !== 1'b1 || opselect !== 4'b0000 || x !== 32'd5) begin
      failures++; $display("FAIL add_latency out_valid=%b opselect=%b x=%h exp 1/0000/5", out_valid, opselect, x);
    end
    offer(6'h08, 6'h00, 16'hFFFF, 5'd4, 5'd0, 32'd10, 32'd0);
    offer(6'h0D, 6'h00, 16'hFFFF, 5'd4, 5'd0, 32'h1234_0000, 32'd9);
    offer(6'h2B, 6'h00, 16'h0010, 5'd6, 5'd0, 32'h100, 32'h0000_DEAD);
    offer(6'h3F, 6'h00, 16'h0001, 5'd6, 5'd2, 32'h1, 32'h2);
    offer(6'h00, 6'h22, 16'h0000, 5'd2, 5'd8, 32'd20, 32'd3);
    offer(6'h00, 6'h24, 16'h0000, 5'd2, 5'd9, 32'hF0F0, 32'hFF00);
    offer(6'h00, 6'h25, 16'h0000, 5'd2, 5'd9, 32'hF0F0, 32'hFF00);
    offer(6'h00, 6'h26, 16'h0000, 5'd2, 5'd9, 32'hF0F0, 32'hFF00);
    offer(6'h00, 6'h27, 16'h0000, 5'd2, 5'd9, 32'hF0F0, 32'hFF00);
    offer(6'h00, 6'h2A, 16'h0000, 5'd2, 5'd9, 32'hFFFF_FFFF, 32'd1);
    offer(6'h00, 6'h21, 16'h0000, 5'd2, 5'd0, 32'd1, 32'd1);
    offer(6'h00, 6'h08, 16'h0000, 5'd2, 5'd5, 32'd1, 32'd1);
    offer(6'h0A, 6'h00, 16'h8000, 5'd11, 5'd0, 32'd3, 32'd0);
    offer(6'h0C, 6'h00, 16'h8001, 5'd12, 5'd0, 32'hFFFF_FFFF, 32'd0);
    offer(6'h0E, 6'h00, 16'hABCD, 5'd13, 5'd0, 32'h5555_5555, 32'd0);
    offer(6'h23, 6'h00, 16'hFFFC, 5'd14, 5'd0, 32'h2000, 32'h77);
    offer(6'h04, 6'h00, 16'h0004, 5'd15, 5'd0, 32'd42, 32'd42);
    offer(6'h09, 6'h00, 16'h7FFF, 5'd0, 5'd0, 32'd1, 32'd0);
    wait_drain("alu_ops");
  endtask

  task automatic test_back_pressure();
    logic [31:0] head_x;
    out_ready = 1'b0;
    offer(6'h00, 6'h20, 16'h0000, 5'd1, 5'd17, 32'h11, 32'h1);
    offer(6'h00, 6'h22, 16'h0000, 5'd2, 5'd18, 32'h22, 32'h2);
    drive(6'h0D, 6'h00, 16'h0033, 5'd19, 5'd0, 32'h33, 32'h3);
    @(negedge clk);
    head_x = x;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || head_x !== 32'h11) begin
      failures++; $display("FAIL full_head out_valid=%b x=%h exp 1/00000011", out_valid, head_x);
    end
    @(negedge clk);
    checks++; if (x !== 32'h11 || opselect !== 4'b0000) begin
      failures++; $display("FAIL stall_stable x=%h opselect=%b exp 00000011/0000", x, opselect);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready); end
    offer(6'h0D, 6'h00, 16'h0033, 5'd19, 5'd0, 32'h33, 32'h3);
    offer(6'h00, 6'h25, 16'h0000, 5'd4, 5'd20, 32'h44, 32'h4);
    wait_drain("back_pressure");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(6'h00, 6'h20, 16'h0000, 5'd1, 5'd21, 32'hA1, 32'h1);
    offer(6'h00, 6'h20, 16'h0000, 5'd1, 5'd22, 32'hA2, 32'h1);
    drive(6'h08, 6'h00, 16'h0005, 5'd23, 5'd0, 32'hA3, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    check_idle("flush");
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped out_valid=%b exp=0", out_valid); end
    out_ready = 1'b1;
    offer(6'h0E, 6'h00, 16'h00FF, 5'd24, 5'd0, 32'h0F0F, 32'h0);
    wait_drain("flush");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(6'h00, 6'h20, 16'h0000, 5'd1, 5'd25, 32'hB1, 32'h1);
    offer(6'h23, 6'h00, 16'h0008, 5'd26, 5'd0, 32'hB2, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(6'h00, 6'h20, 16'h0000, 5'd7, 5'd3, 32'd5, 32'd7);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
